// File: rtl/inst_mem_pipelined.sv
// Instruction memory with a run-time program-load port and a
// READ_LATENCY-deep registered fetch pipeline with backpressure/flush.
module inst_mem_pipelined #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] NOP_WORD     = 32'hE000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  output logic                           req_ready,
  output logic                           resp_valid,
  output logic [31:0]                    resp_data,
  output logic                           resp_err,
  input  logic                           resp_ready,
  input  logic                           flush,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [31:0]                    prog_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned LAST  = READ_LATENCY - 1;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } stage_t;

  // Words are stored XOR NOP_WORD: a zero-initialised RAM
  // therefore reads back as NOP_WORD without an init file.
  logic [31:0] r_mem [DEPTH_WORDS];
  stage_t      r_stg [READ_LATENCY];

  logic                  w_advance;
  logic                  w_accept;
  logic                  w_misal;
  logic                  w_oob;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_rdata;
  stage_t                w_in;

  assign w_advance = !r_stg[LAST].vld || resp_ready;
  assign req_ready = w_advance && !prog_we && !flush && !rst;
  assign w_accept  = req_valid && req_ready;

  assign w_word  = req_addr >> 2;
  assign w_idx   = w_word[IDX_W-1:0];
  assign w_misal = |req_addr[1:0];
  assign w_oob   = w_word >= ADDR_WIDTH'(DEPTH_WORDS);
  assign w_err   = w_misal || w_oob;
  assign w_rdata = r_mem[w_idx] ^ NOP_WORD;

  // Entry captured into stage 1 on an advancing edge.
  always_comb begin
    w_in     = '0;
    w_in.vld = w_accept;
    w_in.err = w_accept && w_err;
    w_in.dat = w_err ? NOP_WORD : w_rdata;
  end

  // Program-load write; independent of reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data ^ NOP_WORD;
    end
  end

  // Response pipeline: reset > flush > advance > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_stg[i].vld <= 1'b0;
        r_stg[i].err <= 1'b0;
        r_stg[i].dat <= NOP_WORD;
      end
    end else if (flush) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_stg[i].vld <= 1'b0;
        r_stg[i].err <= 1'b0;
      end
    end else if (w_advance) begin
      r_stg[0] <= w_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_stg[i] <= r_stg[i-1];
      end
    end
  end

  assign resp_valid = r_stg[LAST].vld;
  assign resp_err   = r_stg[LAST].err;
  assign resp_data  = r_stg[LAST].dat;

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Scoreboard bench for inst_mem_pipelined: expected words queued
// at request acceptance, compared when the response is consumed.
module tb_inst_mem_pipelined;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;
  localparam int IW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'hE000_0000;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          resp_ready = 1'b1;
  logic          flush = 1'b0;
  logic          prog_we = 1'b0;
  logic [IW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;

  exp_t        q[$];
  logic [31:0] model [DEPTH];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_resp = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b1;

  inst_mem_pipelined #(
    .ADDR_WIDTH(32),
    .DEPTH_WORDS(DEPTH),
    .READ_LATENCY(LAT),
    .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .resp_ready(resp_ready),
    .flush(flush),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.cyc = cyc;
    if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) begin
      e.dat = NOP;
      e.err = 1'b1;
    end else begin
      e.dat = model[a[IW+1:2]];
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Monitor: consume response, then drop on flush/reset, then enqueue.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid && resp_ready) begin
      n_resp++;
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_resp: got data %h err %b, required no response",
                 resp_data, resp_err);
      end else begin
        n_pass++;
        e = q.pop_front();
        n_chk++;
        if (resp_data !== e.dat)
          $display("FAIL resp_data: got %h required %h", resp_data, e.dat);
        else n_pass++;
        n_chk++;
        if (resp_err !== e.err)
          $display("FAIL resp_err: got %b required %b", resp_err, e.err);
        else n_pass++;
        if (chk_lat) begin
          n_chk++;
          if (cyc - e.cyc !== LAT)
            $display("FAIL latency: got %0d required %0d", cyc - e.cyc, LAT);
          else n_pass++;
        end
      end
    end
    if (rst || flush) q.delete();
    if (req_valid && req_ready) q.push_back(mk(req_addr));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] a);
    int k;
    k = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: addr %h got no accept, required accept", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic prog(input int idx, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = IW'(idx);
    prog_data = d;
    @(posedge clk);
    #1;
    model[idx] = d;
    prog_we = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    req_valid = 1'b0;
    while (q.size() != 0 && k < 50) begin
      step(1);
      k++;
    end
    n_chk++;
    if (q.size() != 0)
      $display("FAIL drain_timeout: got %0d outstanding required 0", q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1);
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", resp_valid);
    else n_pass++;
    n_chk++;
    if (resp_err !== 1'b0) $display("FAIL rst_err: got %b required 0", resp_err);
    else n_pass++;
    n_chk++;
    if (resp_data !== NOP) $display("FAIL rst_data: got %h required %h", resp_data, NOP);
    else n_pass++;
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b required 0", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL post_rst_ready: got %b required 1", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_fetch();
    int n0;
    prog_we   = 1'b1;
    prog_addr = IW'(1);
    prog_data = 32'hE3A00014;
    @(posedge clk);
    #1;
    model[1]  = 32'hE3A00014;
    prog_addr = IW'(2);
    prog_data = 32'hE3A01A01;
    req_valid = 1'b1;
    req_addr  = 32'd4;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL ready_during_write: got %b required 0", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    model[2] = 32'hE3A01A01;
    prog_we  = 1'b0;
    n0 = n_resp;
    send(32'd4);
    send(32'd8);
    idle();
    drain();
    n_chk++;
    if (n_resp - n0 != 2) $display("FAIL load_fetch_count: got %0d required 2", n_resp - n0);
    else n_pass++;
  endtask

  task automatic test_stream();
    int n0;
    n0 = n_resp;
    send(32'd0);
    send(32'd4);
    send(32'd8);
    send(32'd12);
    idle();
    drain();
    n_chk++;
    if (n_resp - n0 != 4) $display("FAIL stream_count: got %0d required 4", n_resp - n0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int   n0;
    exp_t h;
    for (int i = 9; i <= 13; i++) prog(i, 32'hE3A0_9000 + 32'(i));
    n0 = n_resp;
    h = mk(32'd36);
    chk_lat = 1'b0;
    resp_ready = 1'b0;
    send(32'd36);
    send(32'd40);
    send(32'd44);
    req_addr = 32'd48;
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b0) $display("FAIL bp_ready: got %b required 0", req_ready);
      else n_pass++;
      n_chk++;
      if (resp_valid !== 1'b1 || resp_data !== h.dat)
        $display("FAIL bp_hold: got v=%b %h required v=1 %h", resp_valid, resp_data, h.dat);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    send(32'd48);
    send(32'd52);
    idle();
    drain();
    chk_lat = 1'b1;
    n_chk++;
    if (n_resp - n0 != 5) $display("FAIL bp_count: got %0d required 5", n_resp - n0);
    else n_pass++;
  endtask

  task automatic test_errors();
    send(32'd2);
    send(32'd1024);
    send(32'd1020);
    send(32'h8000_0000);
    send(32'h0000_0403);
    idle();
    drain();
  endtask

  task automatic test_flush();
    int n0;
    send(32'd4);
    send(32'd8);
    flush    = 1'b1;
    req_addr = 32'd12;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL flush_ready: got %b required 0", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    n0 = n_resp;
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b0) $display("FAIL flush_valid: got %b required 0", resp_valid);
    else n_pass++;
    step(6);
    n_chk++;
    if (n_resp != n0) $display("FAIL flush_leak: got %0d responses required 0", n_resp - n0);
    else n_pass++;
  endtask

  task automatic test_hazard();
    prog(5, 32'hE3A05005);
    send(32'd20);
    prog_we   = 1'b1;
    prog_addr = IW'(5);
    prog_data = 32'hE3A0B00B;
    req_addr  = 32'd20;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL hazard_ready: got %b required 0", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    model[5] = 32'hE3A0B00B;
    prog_we  = 1'b0;
    send(32'd20);
    idle();
    drain();
  endtask

  task automatic test_reset_mid();
    send(32'd20);
    send(32'd24);
    rst       = 1'b1;
    flush     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = IW'(7);
    prog_data = 32'hE3A07007;
    req_addr  = 32'd28;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL rstmid_ready: got %b required 0", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    model[7] = 32'hE3A07007;
    rst      = 1'b0;
    flush    = 1'b0;
    prog_we  = 1'b0;
    idle();
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b0 || resp_data !== NOP)
      $display("FAIL rstmid_out: got v=%b %h required v=0 %h", resp_valid, resp_data, NOP);
    else n_pass++;
    @(posedge clk);
    #1;
    send(32'd20);
    send(32'd28);
    send(32'd8);
    idle();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    test_reset();
    test_load_fetch();
    test_stream();
    test_backpressure();
    test_errors();
    test_flush();
    test_hazard();
    test_reset_mid();
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
